img_win_read: RTL and testbench

IMG_WIN_READ -- requirements
Module: img_win_read

---
 rtl/img_win_read_if.sv | 61 ++++++
 rtl/img_win_read.sv | 181 ++++++++++++++++++
 tb/tb_img_win_read.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/img_win_read_if.sv
// ---------------------------------------------------------------------------
// img_win_read_if
// Handshake and address bus between the image-window reader and the conv1
// datapath that consumes its taps.
//   start     : one-cycle pulse that begins a full image scan (consumer -> reader)
//   ready     : conv1 accepts the current tap this cycle      (consumer -> reader)
//   valid     : addr/k_addr/out_addr hold a valid tap          (reader -> consumer)
//   addr      : image memory read address
//   k_addr    : kernel tap index, row-major
//   win_last  : current tap is the last tap of its window
//   out_addr  : conv1 output pixel index of the current window
//   busy      : scan in progress
//   done      : one-cycle pulse after the final tap is accepted
//   stall_cnt : RUN cycles with valid=1 and ready=0 (only with
//               IMG_WIN_READ_STALL_CNT_EN defined)
// Modports: master = reader side, slave = consumer side.
// ---------------------------------------------------------------------------
interface img_win_read_if;
    logic        start;
    logic        ready;
    logic        valid;
    logic [9:0]  addr;
    logic [4:0]  k_addr;
    logic        win_last;
    logic [9:0]  out_addr;
    logic        busy;
    logic        done;
`ifdef IMG_WIN_READ_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    modport master (
        input  start,
        input  ready,
        output valid,
        output addr,
        output k_addr,
        output win_last,
        output out_addr,
        output busy,
`ifdef IMG_WIN_READ_STALL_CNT_EN
        output stall_cnt,
`endif
        output done
    );

    modport slave (
        output start,
        output ready,
        input  valid,
        input  addr,
        input  k_addr,
        input  win_last,
        input  out_addr,
        input  busy,
`ifdef IMG_WIN_READ_STALL_CNT_EN
        input  stall_cnt,
`endif
        input  done
    );
endinterface

// File: rtl/img_win_read.sv
// ---------------------------------------------------------------------------
// img_win_read
// Scans a square IMG_W x IMG_W image held in memory and presents, for every
// conv1 output pixel, the K x K window of image read addresses together with
// the matching kernel tap index and output pixel index.
//
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : img_win_read_if.master (start/ready in; valid, addr, k_addr,
//           win_last, out_addr, busy, done, optional stall_cnt out)
//
// Optional feature: define IMG_WIN_READ_STALL_CNT_EN to add the 16-bit
// saturating stall counter (RUN cycles with valid=1 and ready=0).
//
// State table
//   state  | meaning
//   IDLE   | waiting for start, outputs quiet
//   RUN    | presenting taps, one per accepted transfer
//   DONE   | one-cycle done pulse, then back to IDLE
// ---------------------------------------------------------------------------
module img_win_read #(
    parameter int IMG_W = 28,
    parameter int K     = 5
) (
    input  logic           clk,
    input  logic           reset,
    img_win_read_if.master bus
);

    localparam int OUT_W = IMG_W - K + 1;

    // Jump from the last tap of one kernel row to the first tap of the next.
    localparam logic [9:0] ROW_STEP    = 10'(IMG_W - K + 1);
    localparam logic [9:0] IMG_STEP    = 10'(IMG_W);
    localparam logic [4:0] K_LAST      = 5'(K - 1);
    localparam logic [4:0] O_LAST      = 5'(OUT_W - 1);
    localparam logic [4:0] TAP_PRELAST = 5'(K * K - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic        armed_q;      // low for the first edge after reset release
    logic [4:0]  kcol_q;
    logic [4:0]  krow_q;
    logic [4:0]  ocol_q;
    logic [4:0]  orow_q;
    logic [9:0]  win_base_q;   // image address of tap (0,0) of current window
    logic [9:0]  row_base_q;   // image address of window (orow, 0)
    logic [9:0]  addr_q;
    logic [4:0]  k_addr_q;
    logic [9:0]  out_addr_q;
    logic        valid_q;
    logic        win_last_q;
    logic        busy_q;
    logic        done_q;
`ifdef IMG_WIN_READ_STALL_CNT_EN
    logic [15:0] stall_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            armed_q    <= 1'b0;
            kcol_q     <= '0;
            krow_q     <= '0;
            ocol_q     <= '0;
            orow_q     <= '0;
            win_base_q <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            k_addr_q   <= '0;
            out_addr_q <= '0;
            valid_q    <= 1'b0;
            win_last_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef IMG_WIN_READ_STALL_CNT_EN
            stall_q    <= '0;
`endif
        end else begin
            armed_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start && armed_q) begin
                        state_q    <= S_RUN;
                        kcol_q     <= '0;
                        krow_q     <= '0;
                        ocol_q     <= '0;
                        orow_q     <= '0;
                        win_base_q <= '0;
                        row_base_q <= '0;
                        addr_q     <= '0;
                        k_addr_q   <= '0;
                        out_addr_q <= '0;
                        valid_q    <= 1'b1;
                        win_last_q <= (K == 1);
                        busy_q     <= 1'b1;
`ifdef IMG_WIN_READ_STALL_CNT_EN
                        stall_q    <= '0;
`endif
                    end
                end

                S_RUN: begin
                    if (!bus.ready) begin
`ifdef IMG_WIN_READ_STALL_CNT_EN
                        if (stall_q != 16'hFFFF) begin
                            stall_q <= stall_q + 16'd1;
                        end
`endif
                    end else if (kcol_q != K_LAST) begin
                        kcol_q     <= kcol_q + 5'd1;
                        addr_q     <= addr_q + 10'd1;
                        k_addr_q   <= k_addr_q + 5'd1;
                        win_last_q <= (k_addr_q == TAP_PRELAST);
                    end else if (krow_q != K_LAST) begin
                        kcol_q     <= '0;
                        krow_q     <= krow_q + 5'd1;
                        addr_q     <= addr_q + ROW_STEP;
                        k_addr_q   <= k_addr_q + 5'd1;
                        win_last_q <= (k_addr_q == TAP_PRELAST);
                    end else begin
                        // Window finished: step to the next window base.
                        kcol_q     <= '0;
                        krow_q     <= '0;
                        k_addr_q   <= '0;
                        win_last_q <= 1'b0;
                        if (ocol_q != O_LAST) begin
                            ocol_q     <= ocol_q + 5'd1;
                            win_base_q <= win_base_q + 10'd1;
                            addr_q     <= win_base_q + 10'd1;
                            out_addr_q <= out_addr_q + 10'd1;
                        end else if (orow_q != O_LAST) begin
                            ocol_q     <= '0;
                            orow_q     <= orow_q + 5'd1;
                            row_base_q <= row_base_q + IMG_STEP;
                            win_base_q <= row_base_q + IMG_STEP;
                            addr_q     <= row_base_q + IMG_STEP;
                            out_addr_q <= out_addr_q + 10'd1;
                        end else begin
                            state_q <= S_DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.valid    = valid_q;
    assign bus.addr     = addr_q;
    assign bus.k_addr   = k_addr_q;
    assign bus.win_last = win_last_q;
    assign bus.out_addr = out_addr_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
`ifdef IMG_WIN_READ_STALL_CNT_EN
    assign bus.stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_img_win_read.sv
module tb_img_win_read;

    localparam int IMG_W = 28;
    localparam int K     = 5;
    localparam int OUT_W = 24;
    localparam int KK    = 25;
    localparam int TOTAL = 14400;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    img_win_read_if bus ();

    img_win_read #(.IMG_W(IMG_W), .K(K)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: tap t (0-based, in transfer order) decomposed directly.
    function automatic int e_addr(input int t);
        int w, tp;
        w  = t / KK;
        tp = t % KK;
        return ((w / OUT_W) + (tp / K)) * IMG_W + (w % OUT_W) + (tp % K);
    endfunction

    function automatic int e_k(input int t);
        return t % KK;
    endfunction

    function automatic int e_out(input int t);
        return t / KK;
    endfunction

    function automatic bit e_last(input int t);
        return (t % KK) == (KK - 1);
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.ready = 1'b0;
        #1;
        n_cmp++;
        if ({bus.valid, bus.busy, bus.done, bus.win_last} !== 4'b0 ||
            bus.addr !== 10'd0 || bus.k_addr !== 5'd0 || bus.out_addr !== 10'd0) begin
            n_err++;
            $display("FAIL reset_state: valid=%b busy=%b done=%b last=%b addr=%0d k=%0d out=%0d, want all 0",
                     bus.valid, bus.busy, bus.done, bus.win_last, bus.addr, bus.k_addr, bus.out_addr);
        end
        step();
        step();
        // start held across the first edge after release must be ignored
        @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_cmp++;
        if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL start_at_release: valid=%b busy=%b, want 0 0", bus.valid, bus.busy);
        end
        for (int i = 0; i < 3; i++) step();
        n_cmp++;
        if (bus.valid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_no_start: valid=%b, want 0", bus.valid);
        end
    endtask

    task automatic test_full_scan();
        int first25[25] = '{0, 1, 2, 3, 4, 28, 29, 30, 31, 32, 56, 57, 58, 59, 60,
                            84, 85, 86, 87, 88, 112, 113, 114, 115, 116};
        int t, cyc, done_cyc;
        logic done_valid;
        bus.ready = 1'b1;
        pulse_start();
        t        = 0;
        cyc      = 1;
        done_cyc = -1;
        done_valid = 1'bx;
        while (cyc < 20000 && done_cyc < 0) begin
            if (bus.done === 1'b1) begin
                done_cyc   = cyc;
                done_valid = bus.valid;
            end else begin
                n_cmp++;
                if (bus.valid !== 1'b1 || bus.busy !== 1'b1 ||
                    bus.addr !== 10'(e_addr(t)) || bus.k_addr !== 5'(e_k(t)) ||
                    bus.out_addr !== 10'(e_out(t)) || bus.win_last !== e_last(t)) begin
                    n_err++;
                    $display("FAIL scan_tap t=%0d: valid=%b busy=%b addr=%0d k=%0d out=%0d last=%b, want 1 1 %0d %0d %0d %b",
                             t, bus.valid, bus.busy, bus.addr, bus.k_addr, bus.out_addr, bus.win_last,
                             e_addr(t), e_k(t), e_out(t), e_last(t));
                end
                if (t < 25) begin
                    n_cmp++;
                    if (bus.addr !== 10'(first25[t]) || bus.k_addr !== 5'(t)) begin
                        n_err++;
                        $display("FAIL first_window t=%0d: addr=%0d k=%0d, want %0d %0d",
                                 t, bus.addr, bus.k_addr, first25[t], t);
                    end
                end
                if (t == 25 || t == 600 || t == 14375) begin
                    n_cmp++;
                    if ((t == 25    && (bus.addr !== 10'd1   || bus.out_addr !== 10'd1)) ||
                        (t == 600   && (bus.addr !== 10'd28  || bus.out_addr !== 10'd24)) ||
                        (t == 14375 && (bus.addr !== 10'd667 || bus.out_addr !== 10'd575))) begin
                        n_err++;
                        $display("FAIL window_step t=%0d: addr=%0d out=%0d", t, bus.addr, bus.out_addr);
                    end
                end
                if (t == TOTAL - 1) begin
                    n_cmp++;
                    if (bus.addr !== 10'd783 || bus.out_addr !== 10'd575 || bus.win_last !== 1'b1) begin
                        n_err++;
                        $display("FAIL final_tap: addr=%0d out=%0d last=%b, want 783 575 1",
                                 bus.addr, bus.out_addr, bus.win_last);
                    end
                end
                if (bus.valid === 1'b1 && bus.ready === 1'b1) t++;
            end
            if (done_cyc < 0) begin
                step();
                cyc++;
            end
        end
        n_cmp++;
        if (done_cyc !== 14401 || t !== TOTAL || done_valid !== 1'b0) begin
            n_err++;
            $display("FAIL scan_done: done_cycle=%0d transfers=%0d valid_at_done=%b, want 14401 %0d 0",
                     done_cyc, t, done_valid, TOTAL);
        end
        step();
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
            n_err++;
            $display("FAIL done_one_cycle: done=%b busy=%b valid=%b, want 0 0 0",
                     bus.done, bus.busy, bus.valid);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        bus.ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 7; i++) step();
        n_cmp++;
        if (bus.addr !== 10'd30 || bus.k_addr !== 5'd7) begin
            n_err++;
            $display("FAIL bp_reach: addr=%0d k=%0d, want 30 7", bus.addr, bus.k_addr);
        end
        bus.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (bus.addr !== 10'd30 || bus.k_addr !== 5'd7 || bus.valid !== 1'b1 ||
                bus.out_addr !== 10'd0) begin
                n_err++;
                $display("FAIL bp_hold cyc=%0d: addr=%0d k=%0d valid=%b out=%0d, want 30 7 1 0",
                         i, bus.addr, bus.k_addr, bus.valid, bus.out_addr);
            end
        end
`ifdef IMG_WIN_READ_STALL_CNT_EN
        n_cmp++;
        if (bus.stall_cnt !== 16'd3) begin
            n_err++;
            $display("FAIL stall_cnt_3: got %0d, want 3", bus.stall_cnt);
        end
`endif
        bus.ready = 1'b1;
        step();
        n_cmp++;
        if (bus.addr !== 10'd31 || bus.k_addr !== 5'd8) begin
            n_err++;
            $display("FAIL bp_resume: addr=%0d k=%0d, want 31 8", bus.addr, bus.k_addr);
        end
        bus.ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        bus.ready = 1'b1;
        step();
        n_cmp++;
        if (bus.addr !== 10'd32 || bus.k_addr !== 5'd9) begin
            n_err++;
            $display("FAIL bp_resume2: addr=%0d k=%0d, want 32 9", bus.addr, bus.k_addr);
        end
`ifdef IMG_WIN_READ_STALL_CNT_EN
        n_cmp++;
        if (bus.stall_cnt !== 16'd7) begin
            n_err++;
            $display("FAIL stall_cnt_7: got %0d, want 7", bus.stall_cnt);
        end
`endif
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 20000) begin
            step();
            cyc++;
        end
        n_cmp++;
        if (bus.done !== 1'b1 || cyc !== TOTAL - 9) begin
            n_err++;
            $display("FAIL bp_scan_done: done=%b after %0d cycles, want 1 after %0d",
                     bus.done, cyc, TOTAL - 9);
        end
        step();
`ifdef IMG_WIN_READ_STALL_CNT_EN
        n_cmp++;
        if (bus.stall_cnt !== 16'd7) begin
            n_err++;
            $display("FAIL stall_cnt_idle: got %0d, want 7", bus.stall_cnt);
        end
        pulse_start();
        n_cmp++;
        if (bus.stall_cnt !== 16'd0 || bus.valid !== 1'b1) begin
            n_err++;
            $display("FAIL stall_cnt_clear: cnt=%0d valid=%b, want 0 1", bus.stall_cnt, bus.valid);
        end
        @(negedge clk);
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
`endif
    endtask

    task automatic test_abort();
        int t;
        bus.ready = 1'b1;
        pulse_start();
        t = 0;
        while (t < 5000) begin
            n_cmp++;
            if (bus.valid !== 1'b1 || bus.addr !== 10'(e_addr(t)) ||
                bus.k_addr !== 5'(e_k(t)) || bus.out_addr !== 10'(e_out(t))) begin
                n_err++;
                $display("FAIL abort_tap t=%0d: valid=%b addr=%0d k=%0d out=%0d, want 1 %0d %0d %0d",
                         t, bus.valid, bus.addr, bus.k_addr, bus.out_addr, e_addr(t), e_k(t), e_out(t));
            end
            t++;
            bus.start = (t == 1000 || t == 2501);
            step();
        end
        bus.start = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({bus.valid, bus.busy, bus.done, bus.win_last} !== 4'b0 ||
            bus.addr !== 10'd0 || bus.k_addr !== 5'd0 || bus.out_addr !== 10'd0) begin
            n_err++;
            $display("FAIL abort_reset: valid=%b busy=%b done=%b last=%b addr=%0d k=%0d out=%0d, want all 0",
                     bus.valid, bus.busy, bus.done, bus.win_last, bus.addr, bus.k_addr, bus.out_addr);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (bus.valid !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                n_err++;
                $display("FAIL abort_idle cyc=%0d: valid=%b done=%b busy=%b, want 0 0 0",
                         i, bus.valid, bus.done, bus.busy);
            end
        end
        pulse_start();
        n_cmp++;
        if (bus.valid !== 1'b1 || bus.addr !== 10'd0 || bus.k_addr !== 5'd0 || bus.out_addr !== 10'd0) begin
            n_err++;
            $display("FAIL abort_restart: valid=%b addr=%0d k=%0d out=%0d, want 1 0 0 0",
                     bus.valid, bus.addr, bus.k_addr, bus.out_addr);
        end
        step();
        n_cmp++;
        if (bus.addr !== 10'd1 || bus.k_addr !== 5'd1) begin
            n_err++;
            $display("FAIL abort_restart_step: addr=%0d k=%0d, want 1 1", bus.addr, bus.k_addr);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.ready = 1'b0;
        test_reset();
        test_full_scan();
        test_backpressure();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
